// File: rtl/beep_pulse_stretcher.sv
// beep_pulse_stretcher
//   Turns single-cycle event strobes into human-perceivable beeps: a fixed-length
//   LED level plus a gated square-wave tone. Events arriving while a beep is in
//   progress are queued in a saturating counter and replayed after a silent gap.
//
// Ports
//   CLK    system clock, rising edge
//   CLR    asynchronous reset, active-high
//   TRIG   event strobe, one cycle per event
//   LEVEL  high for the whole ON phase
//   TONE   square wave during ON, 0 otherwise
//   BUSY   high in ON or GAP
//   PEND   queued events not yet started
//   DROP   one-cycle pulse when an event is lost to saturation
module beep_pulse_stretcher #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned ON_MS    = 100,
  parameter int unsigned GAP_MS   = 50,
  parameter int unsigned TONE_DIV = 12500,
  parameter int unsigned PEND_W   = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              TRIG,
  output logic              LEVEL,
  output logic              TONE,
  output logic              BUSY,
  output logic [PEND_W-1:0] PEND,
  output logic              DROP
);

  localparam int unsigned ON_CYC  = ON_MS * TICK_DIV;
  localparam int unsigned GAP_CYC = GAP_MS * TICK_DIV;
  localparam int unsigned MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int unsigned DUR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [DUR_W-1:0]   dur;
  logic [TONE_W-1:0]  tcnt;
  logic [PEND_W-1:0]  pend_n;
  logic               drop_n;
  logic               on_done;
  logic               gap_done;
  logic               enter_on;

  // Duration counter restarts on every state entry, so these are exact phase ends.
  assign on_done  = (dur == DUR_W'(ON_CYC - 1));
  assign gap_done = (dur == DUR_W'(GAP_CYC - 1));
  assign enter_on = (state_n == S_ON) && (state != S_ON);

  // Next-state and queue bookkeeping.
  always_comb begin
    state_n = state;
    pend_n  = PEND;
    drop_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (TRIG) state_n = S_ON;
      end
      S_ON: begin
        if (on_done) state_n = S_GAP;
        if (TRIG) begin
          if (PEND == PEND_MAX) drop_n = 1'b1;
          else                  pend_n = PEND + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          if (PEND != '0) begin
            state_n = S_ON;
            // A coincident TRIG replaces the event being dequeued.
            if (!TRIG) pend_n = PEND - 1'b1;
          end else if (TRIG) begin
            state_n = S_ON;
          end else begin
            state_n = S_IDLE;
          end
        end else if (TRIG) begin
          if (PEND == PEND_MAX) drop_n = 1'b1;
          else                  pend_n = PEND + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= S_IDLE;
      dur   <= '0;
      tcnt  <= '0;
      LEVEL <= 1'b0;
      TONE  <= 1'b0;
      BUSY  <= 1'b0;
      PEND  <= '0;
      DROP  <= 1'b0;
    end else begin
      state <= state_n;
      dur   <= ((state_n != state) || (state_n == S_IDLE)) ? '0 : dur + 1'b1;
      LEVEL <= (state_n == S_ON);
      BUSY  <= (state_n != S_IDLE);
      PEND  <= pend_n;
      DROP  <= drop_n;
      if (enter_on) begin
        TONE <= 1'b1;
        tcnt <= '0;
      end else if (state_n == S_ON) begin
        if (tcnt == TONE_W'(TONE_DIV - 1)) begin
          TONE <= ~TONE;
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        TONE <= 1'b0;
        tcnt <= '0;
      end
    end
  end

endmodule
